// File: rtl/velocity_cell_update_ctrl.sv
// -----------------------------------------------------------------------------
// velocity_cell_update_ctrl
//
// Walks one cell of the particle velocity RAM. Address 0 holds the particle
// count and addresses 1..count hold packed {vz, vy, vx} velocity words. Each
// velocity is read, handed to the motion-update unit over a ready/valid link,
// and the returned value is written back to the same address.
//
// Optional feature macro: VELOCITY_WRITEBACK_EN
//   defined   : the WRITE state pulses mem_wren for one cycle per particle.
//   undefined : the pass sequences with identical timing but mem_wren stays
//               low, so velocities are only streamed out (read-only pass).
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   start           : begin one pass (ignored while busy)
//   busy, done      : pass in progress / one-cycle completion pulse
//   mem_address     : RAM address
//   mem_data        : RAM write data
//   mem_rden        : RAM read enable (mem_q valid one cycle later)
//   mem_wren        : RAM write enable
//   mem_q           : RAM read data
//   vel_out*        : current velocity to the motion-update unit
//   vel_in*         : updated velocity from the motion-update unit
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module velocity_cell_update_ctrl #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [DATA_WIDTH-1:0] vel_out,
    output logic                  vel_out_valid,
    input  logic                  vel_out_ready,
    input  logic [DATA_WIDTH-1:0] vel_in,
    input  logic                  vel_in_valid,
    output logic                  vel_in_ready
);

    // Highest usable particle address; address 0 is the count word.
    localparam logic [ADDR_WIDTH-1:0] MAX_IDX = ADDR_WIDTH'(PARTICLE_NUM - 1);

    typedef enum logic [3:0] {
        IDLE,
        RD_CNT,
        WT_CNT,
        RD_VEL,
        WT_VEL,
        SEND,
        RECV,
        WRITE,
        FIN
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] idx, idx_nxt;
    logic [ADDR_WIDTH-1:0] count, count_nxt;
    logic [DATA_WIDTH-1:0] vel_out_nxt;
    logic [DATA_WIDTH-1:0] mem_data_nxt;
    logic                  wr_turn, wr_turn_nxt;
    logic [ADDR_WIDTH-1:0] cnt_sat;

    // A corrupted or oversized count word must not walk past the RAM depth.
    function automatic logic [ADDR_WIDTH-1:0] sat_count(input logic [ADDR_WIDTH-1:0] raw);
        if (raw > MAX_IDX) begin
            return MAX_IDX;
        end
        return raw;
    endfunction

    assign cnt_sat = sat_count(mem_q[ADDR_WIDTH-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            count    <= '0;
            vel_out  <= '0;
            mem_data <= '0;
            wr_turn  <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            count    <= count_nxt;
            vel_out  <= vel_out_nxt;
            mem_data <= mem_data_nxt;
            wr_turn  <= wr_turn_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        count_nxt     = count;
        vel_out_nxt   = vel_out;
        mem_data_nxt  = mem_data;
        wr_turn_nxt   = wr_turn;
        busy          = 1'b1;
        done          = 1'b0;
        mem_address   = '0;
        mem_rden      = 1'b0;
        mem_wren      = 1'b0;
        vel_out_valid = 1'b0;
        vel_in_ready  = 1'b0;

        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = RD_CNT;
                end
            end

            RD_CNT: begin
                mem_rden  = 1'b1;
                state_nxt = WT_CNT;
            end

            WT_CNT: begin
                count_nxt = cnt_sat;
                if (cnt_sat == '0) begin
                    state_nxt = FIN;
                end else begin
                    idx_nxt   = ADDR_WIDTH'(1);
                    state_nxt = RD_VEL;
                end
            end

            RD_VEL: begin
                mem_address = idx;
                mem_rden    = 1'b1;
                state_nxt   = WT_VEL;
            end

            WT_VEL: begin
                vel_out_nxt = mem_q;
                state_nxt   = SEND;
            end

            SEND: begin
                vel_out_valid = 1'b1;
                if (vel_out_ready) begin
                    state_nxt = RECV;
                end
            end

            RECV: begin
                vel_in_ready = 1'b1;
                if (vel_in_valid) begin
                    mem_data_nxt = vel_in;
                    state_nxt    = WRITE;
                end
            end

            // WRITE spans two cycles: the write strobe, then a turnaround
            // cycle with both enables low before the next read is issued.
            WRITE: begin
                mem_address = idx;
                if (!wr_turn) begin
`ifdef VELOCITY_WRITEBACK_EN
                    mem_wren = 1'b1;
`endif
                    wr_turn_nxt = 1'b1;
                end else begin
                    wr_turn_nxt = 1'b0;
                    if (idx == count) begin
                        state_nxt = FIN;
                    end else begin
                        idx_nxt   = idx + ADDR_WIDTH'(1);
                        state_nxt = RD_VEL;
                    end
                end
            end

            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_velocity_cell_update_ctrl.sv
`timescale 1ns/1ps

module tb_velocity_cell_update_ctrl;

    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;
`ifdef VELOCITY_WRITEBACK_EN
    localparam logic WB = 1'b1;
`else
    localparam logic WB = 1'b0;
`endif

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_exp_t;

    typedef struct {
        logic          wren;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_obs_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_rden;
    logic          mem_wren;
    logic [DW-1:0] mem_q;
    logic [DW-1:0] vel_out;
    logic          vel_out_valid;
    logic          vel_out_ready;
    logic [DW-1:0] vel_in;
    logic          vel_in_valid;
    logic          vel_in_ready;

    velocity_cell_update_ctrl #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .PARTICLE_NUM(PN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .mem_address  (mem_address),
        .mem_data     (mem_data),
        .mem_rden     (mem_rden),
        .mem_wren     (mem_wren),
        .mem_q        (mem_q),
        .vel_out      (vel_out),
        .vel_out_valid(vel_out_valid),
        .vel_out_ready(vel_out_ready),
        .vel_in       (vel_in),
        .vel_in_valid (vel_in_valid),
        .vel_in_ready (vel_in_ready)
    );

    always #5 clk = ~clk;

    // Motion-update unit model: returns the velocity it was handed plus one.
    assign vel_in = vel_out + DW'(1);

    // RAM read model (contents loaded by the stimulus block only).
    logic [DW-1:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_rden) mem_q <= mem[mem_address];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation monitor, sampled mid-cycle.
    logic [DW-1:0] obs_out[$];
    wr_obs_t       obs_wr[$];
    int done_cnt = 0, done_cyc = 0, wren_cnt = 0, rd0_cnt = 0, vov_cnt = 0, viol = 0;
    logic wr_pending = 1'b0;

    always @(negedge clk) begin
        wr_obs_t o;
        if (wr_pending) begin
            o.wren = mem_wren;
            o.addr = mem_address;
            o.data = mem_data;
            obs_wr.push_back(o);
        end
        wr_pending = vel_in_valid && vel_in_ready && !rst;
        if (vel_out_valid && vel_out_ready) obs_out.push_back(vel_out);
        if (vel_out_valid) vov_cnt++;
        if (mem_wren) wren_cnt++;
        if (mem_rden && mem_address == '0) rd0_cnt++;
        if (mem_rden && mem_wren) viol++;
        if (mem_wren && mem_address == '0) viol++;
        if ((mem_rden || mem_wren) && int'(mem_address) >= PN) viol++;
        if (vel_out_valid && vel_in_ready) viol++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard and stimulus.
    int            n_assert = 0;
    int            n_fail   = 0;
    logic [DW-1:0] exp_out[$];
    wr_exp_t       exp_wr[$];
    int            rd_out = 0;
    int            rd_wr  = 0;
    int            start_cyc = 0;
    logic          out_rdy;
    logic          in_vld;

    assign vel_out_ready = out_rdy;
    assign vel_in_valid  = in_vld;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cell(input int cnt_word);
        mem[0] = DW'(cnt_word);
        for (int i = 1; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom};
    endtask

    task automatic expect_range(input int lo, input int hi);
        wr_exp_t e;
        for (int i = lo; i <= hi; i++) begin
            exp_out.push_back(mem[i]);
            e.addr = AW'(i);
            e.data = mem[i] + DW'(1);
            exp_wr.push_back(e);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < budget) begin
            tick();
            k++;
        end
        check({tag, " done_seen"}, 128'(done_cnt != d0), 128'(1));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"}, 128'(busy), 128'(0));
        check({tag, " done"}, 128'(done), 128'(0));
        check({tag, " mem_rden"}, 128'(mem_rden), 128'(0));
        check({tag, " mem_wren"}, 128'(mem_wren), 128'(0));
        check({tag, " vel_out_valid"}, 128'(vel_out_valid), 128'(0));
        check({tag, " vel_in_ready"}, 128'(vel_in_ready), 128'(0));
        check({tag, " mem_address"}, 128'(mem_address), 128'(0));
        check({tag, " mem_data"}, 128'(mem_data), 128'(0));
        check({tag, " vel_out"}, 128'(vel_out), 128'(0));
    endtask

    task automatic drain(input string tag);
        wr_exp_t e;
        wr_obs_t o;
        check({tag, " xfers"}, 128'(obs_out.size() - rd_out), 128'(exp_out.size()));
        while (exp_out.size() > 0 && rd_out < obs_out.size()) begin
            check({tag, " vel_out"}, 128'(obs_out[rd_out]), 128'(exp_out.pop_front()));
            rd_out++;
        end
        exp_out.delete();
        rd_out = obs_out.size();
        check({tag, " writes"}, 128'(obs_wr.size() - rd_wr), 128'(exp_wr.size()));
        while (exp_wr.size() > 0 && rd_wr < obs_wr.size()) begin
            o = obs_wr[rd_wr];
            e = exp_wr.pop_front();
            rd_wr++;
            check({tag, " wr_addr"}, 128'(o.addr), 128'(e.addr));
            check({tag, " wr_data"}, 128'(o.data), 128'(e.data));
            check({tag, " wr_en"}, 128'(o.wren), 128'(WB));
        end
        exp_wr.delete();
        rd_wr = obs_wr.size();
        check({tag, " protocol"}, 128'(viol), 128'(0));
    endtask

    // Pass with ready/valid tied high. Latency is counted inclusively from the
    // cycle start is presented to the cycle done is high.
    task automatic run_full(input string tag, input int cnt_word, input int n);
        int d0, w0, r0, v0;
        load_cell(cnt_word);
        expect_range(1, n);
        d0 = done_cnt;
        w0 = wren_cnt;
        r0 = rd0_cnt;
        v0 = vov_cnt;
        pulse_start();
        wait_done(tag, 2000);
        check({tag, " latency"}, 128'(done_cyc - start_cyc + 2), 128'(3 + 6 * n + 1));
        repeat (3) tick();
        check({tag, " done_pulses"}, 128'(done_cnt - d0), 128'(1));
        check({tag, " busy_after"}, 128'(busy), 128'(0));
        check({tag, " wren_cycles"}, 128'(wren_cnt - w0), WB ? 128'(n) : 128'(0));
        check({tag, " count_reads"}, 128'(rd0_cnt - r0), 128'(1));
        check({tag, " valid_cycles"}, 128'(vov_cnt - v0), 128'(n));
        if (obs_wr.size() > rd_wr) begin
            check({tag, " last_addr"}, 128'(obs_wr[obs_wr.size() - 1].addr), 128'(n));
        end
        drain(tag);
    endtask

    initial begin
        int d0, w0, r0, k;
        rst     = 1'b1;
        start   = 1'b0;
        out_rdy = 1'b1;
        in_vld  = 1'b1;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // start together with reset is dropped
        r0 = rd0_cnt;
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start busy", 128'(busy), 128'(0));
        tick();
        check("rst_start busy2", 128'(busy), 128'(0));
        check("rst_start reads", 128'(rd0_cnt - r0), 128'(0));

        run_full("cnt3", 3, 3);
        run_full("cnt0", 0, 0);

        // vel_out_ready held low for 5 cycles on the first particle
        out_rdy = 1'b0;
        load_cell(2);
        expect_range(1, 2);
        pulse_start();
        k = 0;
        while (!vel_out_valid && k < 20) begin
            tick();
            k++;
        end
        check("stall valid_seen", 128'(vel_out_valid), 128'(1));
        for (int s = 0; s < 5; s++) begin
            check("stall valid_held", 128'(vel_out_valid), 128'(1));
            check("stall vel_stable", 128'(vel_out), 128'(mem[1]));
            tick();
        end
        out_rdy = 1'b1;
        wait_done("stall", 200);
        repeat (2) tick();
        drain("stall");

        run_full("sat255", 255, PN - 1);

        // reset while waiting in RECV of particle 2
        in_vld = 1'b0;
        load_cell(3);
        expect_range(1, 1);
        exp_out.push_back(mem[2]);
        d0 = done_cnt;
        w0 = wren_cnt;
        pulse_start();
        k = 0;
        while (!vel_in_ready && k < 30) begin
            tick();
            k++;
        end
        check("rstmid recv1", 128'(vel_in_ready), 128'(1));
        in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
        k = 0;
        while (!vel_in_ready && k < 30) begin
            tick();
            k++;
        end
        check("rstmid recv2", 128'(vel_in_ready), 128'(1));
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check_idle_outputs("rstmid");
        rst    = 1'b0;
        in_vld = 1'b1;
        repeat (10) tick();
        check("rstmid done", 128'(done_cnt - d0), 128'(0));
        check("rstmid wren", 128'(wren_cnt - w0), WB ? 128'(1) : 128'(0));
        drain("rstmid");

        // start re-pulsed mid-pass: no restart, nothing queued
        load_cell(3);
        expect_range(1, 3);
        d0 = done_cnt;
        w0 = wren_cnt;
        r0 = rd0_cnt;
        pulse_start();
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("restart", 100);
        check("restart latency", 128'(done_cyc - start_cyc + 2), 128'(22));
        repeat (5) tick();
        check("restart busy", 128'(busy), 128'(0));
        check("restart done", 128'(done_cnt - d0), 128'(1));
        check("restart reads", 128'(rd0_cnt - r0), 128'(1));
        check("restart wren", 128'(wren_cnt - w0), WB ? 128'(3) : 128'(0));
        drain("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/velocity_cell_update_ctrl.md
VELOCITY_CELL_UPDATE_CTRL -- requirements
Module: velocity_cell_update_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 96, meaning the velocity word width, packed {vz, vy, vx}, 32 bits each.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning the cell velocity RAM address width.
REQ-003 SHALL have parameter PARTICLE_NUM, default 220, meaning the RAM depth including the count word at address 0.
REQ-004 SHALL have port clk, input, 1 bit: the single clock. Reset is synchronous and active-high.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port start, input, 1 bit: begin one update pass over the cell.
REQ-007 SHALL have port busy, output, 1 bit: high while a pass is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when a pass completes.
REQ-009 SHALL have port mem_address, output, ADDR_WIDTH bits: RAM address.
REQ-010 SHALL have port mem_data, output, DATA_WIDTH bits: RAM write data.
REQ-011 SHALL have ports mem_rden and mem_wren, output, 1 bit each: RAM read and write enables.
REQ-012 SHALL have port mem_q, input, DATA_WIDTH bits: RAM read data, valid 1 cycle after mem_rden.
REQ-013 SHALL have port vel_out, output, DATA_WIDTH bits, with vel_out_valid (output, 1 bit) and vel_out_ready (input, 1 bit): current velocity sent to the motion-update unit.
REQ-014 SHALL have port vel_in, input, DATA_WIDTH bits, with vel_in_valid (input, 1 bit) and vel_in_ready (output, 1 bit): updated velocity returned by the motion-update unit.

Function
REQ-015 SHALL implement the FSM states IDLE, RD_CNT, WT_CNT, RD_VEL, WT_VEL, SEND, RECV, WRITE, FIN.
REQ-016 IDLE: start=1 SHALL go to RD_CNT. busy=0 only in IDLE.
REQ-017 RD_CNT: SHALL drive mem_address=0 and mem_rden=1 for 1 cycle. WT_CNT: SHALL latch count=mem_q[ADDR_WIDTH-1:0].
REQ-018 SHALL saturate the latched count to PARTICLE_NUM-1.
REQ-019 If count=0, WT_CNT SHALL go to FIN. Otherwise it SHALL set idx=1 and go to RD_VEL.
REQ-020 RD_VEL: SHALL drive mem_address=idx and mem_rden=1 for 1 cycle. WT_VEL: SHALL latch mem_q into the vel_out register and go to SEND.
REQ-021 SEND: SHALL hold vel_out_valid=1 with vel_out stable until vel_out_ready=1. The transfer occurs on the edge where both are high, then the FSM goes to RECV.
REQ-022 RECV: SHALL hold vel_in_ready=1. On vel_in_valid=1 it SHALL latch vel_in into mem_data and go to WRITE.
REQ-023 WRITE: SHALL drive mem_address=idx and mem_wren=1 for exactly 1 cycle.
REQ-024 WRITE: if idx=count, SHALL go to FIN. Otherwise it SHALL set idx=idx+1 and go to RD_VEL.
REQ-025 FIN: SHALL assert done=1 for 1 cycle, then go to IDLE.
REQ-026 mem_rden and mem_wren SHALL never be high in the same cycle. Both SHALL be 0 outside RD_CNT, RD_VEL and WRITE.
REQ-027 start asserted while busy=1 SHALL be ignored, and SHALL not be queued.
REQ-028 Address 0 (the count word) SHALL never be written.
REQ-029 vel_out_valid and vel_in_ready SHALL never be high in the same cycle.
REQ-030 vel_in_valid outside RECV SHALL be ignored and SHALL not be captured.
REQ-031 Per-particle latency with ready/valid tied high SHALL be 6 cycles (RD_VEL, WT_VEL, SEND, RECV, WRITE, plus 1 turnaround). A full pass SHALL take 3 + 6*count + 1 cycles.

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE, including mid-pass. The partially processed cell is left as-is, with no further writes.
REQ-033 On reset, SHALL drive busy=0, done=0, mem_rden=0, mem_wren=0, vel_out_valid=0 and vel_in_ready=0.
REQ-034 On reset, SHALL clear mem_address, mem_data, vel_out, idx and count to 0.
REQ-035 start sampled in the same cycle as rst=1 SHALL be ignored.

Configuration
REQ-036 The feature macro SHALL be VELOCITY_WRITEBACK_EN.
REQ-037 When VELOCITY_WRITEBACK_EN is defined, the WRITE state SHALL assert mem_wren as in REQ-023.
REQ-038 When VELOCITY_WRITEBACK_EN is undefined, the WRITE state SHALL still sequence, but mem_wren SHALL be held at 0. The pass then streams velocities read-only, and cycle timing is unchanged.

Verification
REQ-039 Bench SHALL cover: count=3 at addr 0, velocities V1..V3, ready/valid tied 1, returned value = Vi+1 -> writes at addr 1,2,3 with Vi+1, and done at cycle 3+18+1=22 after start.
REQ-040 Bench SHALL cover: count=0 -> no vel_out_valid, no mem_wren, and done pulses 4 cycles after start.
REQ-041 Bench SHALL cover: count=2, vel_out_ready held low 5 cycles -> vel_out stable and valid held for all 5 cycles, with 1 transfer only.
REQ-042 Bench SHALL cover: count=255 stored with PARTICLE_NUM=220 -> the last write is at addr 219, and addr 220+ is never accessed.
REQ-043 Bench SHALL cover: rst pulsed during RECV of particle 2 -> IDLE next cycle, all outputs 0, no write to addr 2.
REQ-044 Bench SHALL cover: start re-pulsed mid-pass, plus a build without VELOCITY_WRITEBACK_EN -> no restart, and mem_wren never 1 in that build.
